// File: rtl/led_pattern_sequencer.sv
// LED bank driver: four patterns (count, walk, bounce, blink) advanced by a
// prescaled tick, with a debounced push-button that steps the active pattern.
module led_pattern_sequencer #(
  parameter int BITS          = 8,
  parameter int LOG2DELAY     = 22,
  parameter int DEBOUNCE_LOG2 = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_next,
  input  logic            hold,
  output logic [BITS-1:0] led,
  output logic [1:0]      mode,
  output logic            tick
);

  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [LOG2DELAY-1:0]     PRESC_MAX = '1;
  localparam logic [LOG2DELAY-1:0]     PRESC_ONE = LOG2DELAY'(1);
  localparam logic [DEBOUNCE_LOG2-1:0] DB_MAX    = '1;
  localparam logic [DEBOUNCE_LOG2-1:0] DB_ONE    = DEBOUNCE_LOG2'(1);
  localparam logic [BITS-1:0]          LED_ONE   = BITS'(1);
  localparam logic [BITS-1:0]          LED_END   = LED_ONE << (BITS - 1);

  logic                     s1_q, s2_q;
  logic                     db_level_q, db_level_d;
  logic [DEBOUNCE_LOG2-1:0] db_cnt_q, db_cnt_d;
  logic [LOG2DELAY-1:0]     presc_q, presc_d;
  logic [BITS-1:0]          led_q, led_d, led_step, led_init;
  logic [1:0]               mode_q, mode_d;
  logic                     dir_q, dir_d, dir_step;
  logic                     tick_q, tick_d;
  logic                     btn_diff, db_flip, press, advance;

  // dir_q: 0 moves the bounce bit towards the MSB, 1 towards bit 0.
  always_comb begin
    btn_diff   = s2_q != db_level_q;
    db_flip    = btn_diff && (db_cnt_q == DB_MAX);
    press      = db_flip && s2_q;
    db_level_d = db_flip ? s2_q : db_level_q;
    db_cnt_d   = (btn_diff && !db_flip) ? db_cnt_q + DB_ONE : '0;
    advance    = (presc_q == PRESC_MAX) && !hold;
  end

  always_comb begin
    led_step = led_q;
    dir_step = dir_q;
    case (mode_q)
      MODE_COUNT: led_step = led_q + LED_ONE;
      MODE_WALK:  led_step = {led_q[BITS-2:0], led_q[BITS-1]};
      MODE_BOUNCE: begin
        if (!dir_q) begin
          if (led_q[BITS-1]) begin
            led_step = LED_END >> 1;
            dir_step = 1'b1;
          end else begin
            led_step = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            led_step = LED_ONE << 1;
            dir_step = 1'b0;
          end else begin
            led_step = led_q >> 1;
          end
        end
      end
      default:    led_step = ~led_q;
    endcase
  end

  always_comb begin
    mode_d   = mode_q + 2'd1;
    led_init = '0;
    case (mode_d)
      MODE_COUNT:  led_init = '0;
      MODE_WALK:   led_init = LED_ONE;
      MODE_BOUNCE: led_init = LED_ONE;
      default:     led_init = '1;
    endcase
  end

  // A press outranks a coincident advance: the advance is simply dropped.
  always_comb begin
    presc_d = presc_q;
    led_d   = led_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    if (press) begin
      presc_d = '0;
      led_d   = led_init;
      dir_d   = 1'b0;
    end else begin
      if (!hold) presc_d = presc_q + PRESC_ONE;
      if (advance) begin
        tick_d = 1'b1;
        led_d  = led_step;
        dir_d  = dir_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      presc_q    <= '0;
      led_q      <= '0;
      mode_q     <= MODE_COUNT;
      dir_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      s1_q       <= btn_next;
      s2_q       <= s1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      presc_q    <= presc_d;
      led_q      <= led_d;
      if (press) mode_q <= mode_d;
      dir_q      <= dir_d;
      tick_q     <= tick_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed vector table, hand-written corner
// sequences and random button/hold/reset traffic against a pattern-index model.
module tb_led_pattern_sequencer;

  localparam int BITS          = 8;
  localparam int LOG2DELAY     = 2;
  localparam int DEBOUNCE_LOG2 = 2;
  localparam int PMAX          = (1 << LOG2DELAY) - 1;
  localparam int DB_MAX        = (1 << DEBOUNCE_LOG2) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            btn_next = 1'b0;
  logic            hold = 1'b0;
  logic [BITS-1:0] led;
  logic [1:0]      mode;
  logic            tick;

  int n_cmp = 0;
  int n_err = 0;

  led_pattern_sequencer #(
    .BITS(BITS), .LOG2DELAY(LOG2DELAY), .DEBOUNCE_LOG2(DEBOUNCE_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .hold(hold),
    .led(led), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: the LED value is a function of the mode and how many
  // ticks have elapsed since the mode was entered.
  int m_mode = 0, m_idx = 0, m_presc = 0, m_dbcnt = 0;
  bit m_s1 = 0, m_s2 = 0, m_db = 0, m_tick = 0;

  function automatic int model_led();
    int k, pos;
    case (m_mode)
      0: return m_idx % (1 << BITS);
      1: return 1 << (m_idx % BITS);
      2: begin
        k   = m_idx % (2 * BITS - 2);
        pos = (k < BITS) ? k : (2 * BITS - 2 - k);
        return 1 << pos;
      end
      default: return (m_idx % 2 == 0) ? (1 << BITS) - 1 : 0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit b, input bit h);
    bit press, adv;
    if (r) begin
      m_mode = 0; m_idx = 0; m_presc = 0; m_dbcnt = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_tick = 0;
    end else begin
      press = (m_s2 != m_db) && (m_dbcnt == DB_MAX) && m_s2;
      adv   = (m_presc == PMAX) && !h;
      if (m_s2 != m_db) begin
        if (m_dbcnt == DB_MAX) begin
          m_db = m_s2;
          m_dbcnt = 0;
        end else begin
          m_dbcnt++;
        end
      end else begin
        m_dbcnt = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
      if (press) begin
        m_mode = (m_mode + 1) % 4;
        m_idx = 0; m_presc = 0; m_tick = 0;
      end else begin
        m_tick = adv;
        if (adv) m_idx++;
        if (!h) m_presc = (m_presc + 1) % (PMAX + 1);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge worth of inputs, then compare outputs just after the edge.
  task automatic step(input bit r, input bit b, input bit h);
    rst = r; btn_next = b; hold = h;
    model_edge(r, b, h);
    @(posedge clk);
    #1;
    check("model_led", 32'(led), 32'(model_led()));
    check("model_mode", 32'(mode), 32'(m_mode));
    check("model_tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic press_release(input bit h);
    repeat (10) step(0, 1, h);
    repeat (10) step(0, 0, 0);
  endtask

  typedef struct {
    bit          r, b, h;
    logic [7:0]  led;
    logic [1:0]  mode;
    logic        tick;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int   run;
    bit   rb, rh, rr;
    logic [1:0] saved_mode;

    vecs[0]  = '{1, 0, 0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{0, 0, 0, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{0, 0, 0, 8'h00, 2'd0, 1'b0};
    vecs[3]  = '{0, 0, 0, 8'h00, 2'd0, 1'b0};
    vecs[4]  = '{0, 0, 0, 8'h01, 2'd0, 1'b1};
    vecs[5]  = '{0, 0, 0, 8'h01, 2'd0, 1'b0};
    vecs[6]  = '{0, 0, 1, 8'h01, 2'd0, 1'b0};
    vecs[7]  = '{0, 0, 1, 8'h01, 2'd0, 1'b0};
    vecs[8]  = '{0, 0, 0, 8'h01, 2'd0, 1'b0};
    vecs[9]  = '{0, 0, 0, 8'h01, 2'd0, 1'b0};
    vecs[10] = '{0, 0, 0, 8'h02, 2'd0, 1'b1};
    vecs[11] = '{0, 0, 0, 8'h02, 2'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].r, vecs[i].b, vecs[i].h);
      check("vec_led", 32'(led), 32'(vecs[i].led));
      check("vec_mode", 32'(mode), 32'(vecs[i].mode));
      check("vec_tick", 32'(tick), 32'(vecs[i].tick));
    end

    // COUNT wrap: tick 255 shows 0xFF, tick 256 shows 0x00.
    step(1, 0, 0);
    repeat (1020) step(0, 0, 0);
    check("wrap_pre_led", 32'(led), 32'hFF);
    repeat (4) step(0, 0, 0);
    check("wrap_led", 32'(led), 32'h00);
    check("wrap_tick", 32'(tick), 32'h1);

    // First press lands on edge 6 of a held button.
    step(1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0);
      if (i == 5) check("press_e5_mode", 32'(mode), 32'd0);
      if (i == 6) begin
        check("press_e6_mode", 32'(mode), 32'd1);
        check("press_e6_led", 32'(led), 32'h01);
      end
    end
    repeat (40) step(0, 0, 0);
    check("walk_one_change", 32'(mode), 32'd1);
    press_release(0);
    check("bounce_mode", 32'(mode), 32'd2);
    repeat (60) step(0, 0, 0);
    press_release(0);
    check("blink_mode", 32'(mode), 32'd3);
    repeat (16) step(0, 0, 0);
    press_release(1);
    check("back_count_mode", 32'(mode), 32'd0);

    // Glitches of 1, 2 and 3 cycles never register.
    saved_mode = mode;
    step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    check("glitch_mode", 32'(mode), 32'(saved_mode));

    // Debounce flip coincides with an advance edge (edge 8 after reset).
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    repeat (6) step(0, 1, 0);
    check("coinc_mode", 32'(mode), 32'd1);
    check("coinc_led", 32'(led), 32'h01);
    check("coinc_tick", 32'(tick), 32'h0);
    repeat (10) step(0, 0, 0);

    // hold freezes COUNT at 5, advance resumes on the 4th edge after release.
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    check("hold_start_led", 32'(led), 32'd5);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1);
      check("hold_led", 32'(led), 32'd5);
      check("hold_tick", 32'(tick), 32'd0);
    end
    repeat (3) step(0, 0, 0);
    check("resume_early_tick", 32'(tick), 32'd0);
    step(0, 0, 0);
    check("resume_tick", 32'(tick), 32'd1);
    check("resume_led", 32'(led), 32'd6);

    // Reset in the middle of BOUNCE.
    step(1, 0, 0);
    press_release(0);
    press_release(0);
    repeat (13) step(0, 0, 0);
    step(1, 0, 0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);

    // Random button runs, occasional hold and rare resets.
    run = 0;
    rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        rb  = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 12);
      end
      run--;
      rh = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rb, rh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Drives the board LED bank with one of four selectable patterns, each advanced at a slow prescaled rate.
- A single push-button steps the active pattern mode; the button input is synchronised and debounced inside the block.
- Sits between the board clock buffer and the LED pins, and replaces the bare free-running LED counter in board tops.

Parameters:
- BITS, 8, LED bank width; must be >= 2.
- LOG2DELAY, 22, prescaler width; a tick fires every 2^LOG2DELAY un-held cycles; must be >= 1.
- DEBOUNCE_LOG2, 16, button must be stable for 2^DEBOUNCE_LOG2 cycles to register; must be >= 1.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- btn_next  input  1  raw asynchronous button level; a press is a debounced rising edge.
- hold  input  1  while high, the prescaler freezes and no ticks occur.
- led  output  BITS  current pattern, driven directly from a register.
- mode  output  2  active mode: 0=COUNT, 1=WALK, 2=BOUNCE, 3=BLINK.
- tick  output  1  registered one-cycle pulse marking a pattern advance.

Behaviour:
- Reset (rst high at an edge): mode=COUNT, led=0, tick=0, prescaler=0, dir=left, sync flops=0, debounce level=0, debounce counter=0. Reset overrides every other event, including mid-pattern and mid-debounce.
- Prescaler: LOG2DELAY-bit up-counter, incremented each cycle when hold=0; wraps all-ones→0.
- Advance condition: prescaler==all-ones and hold=0.
  - On that edge: tick register is set to 1 and the pattern steps.
  - tick and the new led value are therefore visible together in the following cycle.
  - tick is 0 in all other cycles.
- Button synchroniser: 2-FF synchroniser producing s2.
- Debouncer:
  - When s2 != db_level, the debounce counter increments; otherwise it clears.
  - When the counter == 2^DEBOUNCE_LOG2-1 and s2 != db_level, db_level takes s2 and the counter clears.
- Press:
  - A press is the edge on which db_level goes 0→1.
  - With btn_next held high, counting the first edge that samples it high as edge 1, mode changes on edge 2^DEBOUNCE_LOG2+2.
  - Any btn_next high pulse shorter than 2^DEBOUNCE_LOG2 cycles produces no press.
  - Release edges never change mode.
- Mode FSM: on each press, COUNT→WALK→BOUNCE→BLINK→COUNT. On the press edge:
  - prescaler is cleared;
  - tick is forced to 0;
  - led is loaded with the new mode's initial value: COUNT 0, WALK 1, BOUNCE 1 with dir=left, BLINK all-ones.
- Pattern step, per mode, on each advance:
  - COUNT: led+1, modulo 2^BITS (all-ones wraps to 0).
  - WALK: rotate left by 1; the MSB wraps to bit 0.
  - BOUNCE: the one-hot bit moves in direction dir.
    - At bit BITS-1 moving left: dir flips to right and led becomes bit BITS-2.
    - At bit 0 moving right: dir flips to left and led becomes bit 1.
    - The end bit is never shown twice in a row.
  - BLINK: led = ~led.
- Simultaneous press and advance: the press wins; the initial value is loaded, tick=0, and the advance is discarded.
- hold during a press: the mode still changes and the initial value loads; the prescaler stays at 0 until hold drops.
- hold does not affect the debouncer.

Test Plan (BITS=8, LOG2DELAY=2, DEBOUNCE_LOG2=2, btn_next=0, hold=0 unless stated):
- Reset, then run 40 cycles → after reset led=0, mode=0, tick=0. tick pulses every 4th cycle. led reads 1,2,3,... concurrent with each tick. Preload near wrap: after 255 ticks led=255, next tick led=0.
- btn_next high 10 cycles → mode=1 on edge 6. led=0x01 on that edge. Subsequent ticks give 0x02,0x04,...,0x80,0x01. Exactly one mode change.
- Second press → mode=2, led=0x01. Ticks give 0x02,...,0x80,0x40,...,0x01,0x02; no repeated 0x80 or 0x01.
- Third press → mode=3, led=0xFF. Ticks toggle 0x00,0xFF. Fourth press → mode=0, led=0x00.
- btn_next pulses of 1, 2 and 3 cycles separated by 1-cycle lows → mode unchanged. Press aligned so the debounce flip lands on an advance edge → mode advances, led=initial value, tick=0 that cycle.
- hold=1 for 20 cycles in COUNT at led=5 → led stays 5, tick stays 0; advance resumes 4 cycles after hold drops. rst pulse mid-BOUNCE → next cycle led=0, mode=0, tick=0.
